// File: rtl/frame_buffers_ring_controller.sv
// frame_buffers_ring_controller
//   Ownership controller for NUM_BUFFERS frame buffers shared between the
//   rasteriser (writes the target) and display scan-out (reads the source).
//   Completed frames wait in an in-order ready queue of depth NUM_BUFFERS-2.
//   With MAILBOX=1 the rasteriser never stalls: when no buffer is free it
//   recycles the oldest queued frame. With MAILBOX=0 it stalls until a
//   display swap frees a buffer.
// Ports:
//   i_clk, i_arst_n               clock, async active-low reset
//   i_raster_in_progress          high while the target is being drawn
//   i_frame_buffer_swap_allowed   high during vblank
//   o_new_frame                   fresh target handed out, raster not started
//   o_rasterization_target        buffer index the rasteriser writes
//   o_display_source              buffer index scan-out reads
//   o_frames_pending              ready-queue occupancy
//   o_stalled                     completed frame has nowhere to go
//   o_frame_dropped               one-cycle pulse on mailbox recycling
module frame_buffers_ring_controller #(
  parameter int NUM_BUFFERS = 3,
  parameter bit MAILBOX     = 1'b1,
  localparam int IDX_W      = (NUM_BUFFERS > 2) ? $clog2(NUM_BUFFERS) : 1
) (
  input  logic             i_clk,
  input  logic             i_arst_n,
  input  logic             i_raster_in_progress,
  input  logic             i_frame_buffer_swap_allowed,
  output logic             o_new_frame,
  output logic [IDX_W-1:0] o_rasterization_target,
  output logic [IDX_W-1:0] o_display_source,
  output logic [IDX_W:0]   o_frames_pending,
  output logic             o_stalled,
  output logic             o_frame_dropped
);

  localparam int Q  = NUM_BUFFERS - 2;
  localparam int QD = (Q > 0) ? Q : 1;
  // buffers 2..N-1 start free; 0 is displayed, 1 is the first target
  localparam logic [NUM_BUFFERS-1:0] FREE_RST = ~(NUM_BUFFERS'(3));

  typedef enum logic [2:0] {
    FRAME_READY        = 3'b001,
    RASTER_IN_PROGRESS = 3'b010,
    FRAME_FINISHED     = 3'b100
  } state_t;

  state_t                 state, n_state;
  logic [IDX_W-1:0]       tgt, n_tgt, disp, n_disp, sel;
  logic [IDX_W-1:0]       q [QD];
  logic [IDX_W-1:0]       n_q [QD];
  logic [IDX_W:0]         cnt, n_cnt;
  logic [NUM_BUFFERS-1:0] free, n_free;
  logic                   drop, n_drop;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state <= FRAME_READY;
      tgt   <= IDX_W'(1);
      disp  <= '0;
      cnt   <= '0;
      free  <= FREE_RST;
      drop  <= 1'b0;
      for (int i = 0; i < QD; i++) q[i] <= '0;
    end else begin
      state <= n_state;
      tgt   <= n_tgt;
      disp  <= n_disp;
      cnt   <= n_cnt;
      free  <= n_free;
      drop  <= n_drop;
      for (int i = 0; i < QD; i++) q[i] <= n_q[i];
    end
  end

  always_comb begin
    n_state = state;
    n_tgt   = tgt;
    n_disp  = disp;
    n_cnt   = cnt;
    n_free  = free;
    n_drop  = 1'b0;
    sel     = '0;
    for (int i = 0; i < QD; i++) n_q[i] = q[i];

    // Ordinary vblank swap: applied before any raster completion in the same
    // cycle so the buffer it frees can take the completing frame.
    if (state != FRAME_FINISHED && i_frame_buffer_swap_allowed && cnt != '0) begin
      n_disp       = q[0];
      n_free[disp] = 1'b1;
      for (int i = 0; i < QD - 1; i++) n_q[i] = n_q[i+1];
      n_cnt = cnt - 1'b1;
    end

    case (state)
      FRAME_READY: begin
        if (i_raster_in_progress) n_state = RASTER_IN_PROGRESS;
      end
      RASTER_IN_PROGRESS: begin
        if (!i_raster_in_progress) begin
          if (|n_free) begin
            for (int i = NUM_BUFFERS - 1; i >= 0; i--)
              if (n_free[i]) sel = IDX_W'(i);
            for (int i = 0; i < QD; i++)
              if ((IDX_W+1)'(i) == n_cnt) n_q[i] = tgt;
            n_cnt       = n_cnt + 1'b1;
            n_tgt       = sel;
            n_free[sel] = 1'b0;
            n_state     = FRAME_READY;
          end else if (MAILBOX && Q > 0) begin
            // no free buffer means the queue is full: recycle its head and
            // append the new frame at the tail
            n_tgt = n_q[0];
            for (int i = 0; i < QD - 1; i++) n_q[i] = n_q[i+1];
            n_q[QD-1] = tgt;
            n_drop    = 1'b1;
            n_state   = FRAME_READY;
          end else begin
            n_state = FRAME_FINISHED;
          end
        end
      end
      FRAME_FINISHED: begin
        // the old display becomes the next target directly; it never
        // passes through the free set
        if (i_frame_buffer_swap_allowed && (Q == 0 || cnt != '0)) begin
          n_tgt   = disp;
          n_state = FRAME_READY;
          if (Q == 0) begin
            n_disp = tgt;
          end else begin
            n_disp = q[0];
            for (int i = 0; i < QD - 1; i++) n_q[i] = n_q[i+1];
            for (int i = 0; i < QD; i++)
              if ((IDX_W+1)'(i) == cnt - 1'b1) n_q[i] = tgt;
          end
        end
      end
      default: n_state = FRAME_READY;
    endcase
  end

  assign o_new_frame            = (state == FRAME_READY);
  assign o_stalled              = (state == FRAME_FINISHED);
  assign o_rasterization_target = tgt;
  assign o_display_source       = disp;
  assign o_frames_pending       = cnt;
  assign o_frame_dropped        = drop;

endmodule

// File: doc/frame_buffers_ring_controller.md
Name: frame_buffers_ring_controller

Overview:
- Generalised frame-buffer ownership controller for 2..8 frame buffers; successor to the double-buffer swap controller.
- Arbitrates between the rasteriser (writes the target buffer) and the display scan-out (reads the source buffer).
- Completed frames are held in an in-order ready queue. In mailbox mode the rasteriser never stalls; it recycles the oldest unshown frame.
- Sits between rasteriser control and display timing. Drives buffer-select indices to the memory arbiter.

Parameters:
- NUM_BUFFERS, 3, number of frame buffers; legal 2..8. Ready-queue depth Q = NUM_BUFFERS-2.
- MAILBOX, 1, 1 = drop oldest queued frame when no buffer is free; 0 = stall the rasteriser until scan-out frees a buffer.
- IDX_W, derived = max(1,$clog2(NUM_BUFFERS)), index width; not overridable.

Ports:
- i_clk  in  1  clock
- i_arst_n  in  1  asynchronous active-low reset
- i_raster_in_progress  in  1  level; high while rasteriser draws into o_rasterization_target
- i_frame_buffer_swap_allowed  in  1  level; high during display vblank, when the source may change
- o_new_frame  out  1  level; high while a fresh target is ready and the raster has not started
- o_rasterization_target  out  IDX_W  buffer the rasteriser writes
- o_display_source  out  IDX_W  buffer scan-out reads
- o_frames_pending  out  IDX_W+1  ready-queue occupancy, 0..Q
- o_stalled  out  1  high in FRAME_FINISHED (completed frame with nowhere to go)
- o_frame_dropped  out  1  one-cycle pulse when mailbox recycling discards a queued frame

Behaviour:
- Reset (async assert, sync-released by the caller):
  - display=0, target=1, queue empty, free set = {2..N-1}
  - state FRAME_READY, o_new_frame=1, o_stalled=0, o_frame_dropped=0, o_frames_pending=0
- Invariant: every index is in exactly one role (target, display, queued, free).
- Free selection: lowest-index free buffer (priority encoder).
- One-hot FSM:
  - FRAME_READY: o_new_frame=1. i_raster_in_progress=1 -> RASTER_IN_PROGRESS, o_new_frame=0 next cycle.
  - RASTER_IN_PROGRESS: on i_raster_in_progress=0, frame C=target completes.
    - Free buffer exists: push C, target <= lowest free -> FRAME_READY.
    - Else if MAILBOX=1 and Q>0: pop oldest queued index H, target <= H, push C, pulse o_frame_dropped -> FRAME_READY.
    - Else -> FRAME_FINISHED.
  - FRAME_FINISHED: o_stalled=1, C held. On swap event:
    - Q=0: display <= C, target <= old display.
    - Q>0: display <= queue head, target <= old display, push C.
    - Then -> FRAME_READY. Matches classic double-buffer behaviour when N=2.
  - Illegal state encoding -> FRAME_READY; indices unchanged.
- Swap event = i_frame_buffer_swap_allowed=1 and queue non-empty (or FRAME_FINISHED with Q=0):
  - Queue not empty: display <= head, pop, old display -> free.
  - At most one swap per cycle; a held-high allowed drains one frame per cycle.
  - Empty queue: display unchanged.
- Simultaneous swap event and raster completion in one cycle: the swap is applied first, and the buffer it frees is eligible for the completing frame. No drop and no stall occurs if the swap freed a buffer.
- All index/role updates are registered and visible the cycle after the deciding edge. o_frames_pending reflects the post-update occupancy.
- Reset mid-frame returns to reset roles immediately. In-flight and queued frames are discarded.
- o_frame_dropped is never asserted when MAILBOX=0 or N=2.

Test Plan:
- Reset -> target=1, display=0, o_new_frame=1, pending=0, o_stalled=0; holds with inputs low.
- N=3, MAILBOX=1: raster pulse, no swap -> pending=1, target=2. Second raster pulse -> o_frame_dropped 1 cycle, target=1, pending=1 (queue holds 2). Swap -> display=2, target stays 1, pending=0.
- N=3, MAILBOX=0: two raster pulses with no swap -> o_stalled=1, target frozen at 2. Swap -> display=1, target=0, queue holds 2, o_new_frame=1, stall cleared.
- N=2: raster done -> FRAME_FINISHED. Swap -> target 1->0, display 0->1, o_new_frame=1; repeat toggles back.
- N=4: swap_allowed held high while raster completes in the same cycle, queue=[1] -> display=1, 0 freed, target=0, no drop, pending=1.
- Assert i_arst_n low mid-RASTER_IN_PROGRESS with pending=1 -> outputs return to reset values asynchronously, before the next clock edge.
